// File: rtl/adc_sample_averager_pkg.sv
// -----------------------------------------------------------------------------
// sunflower_pkg
// Shared definitions for the sunflower light-sensing path: ADC word width,
// default sampling/averaging parameters and the averager state encoding.
// -----------------------------------------------------------------------------
package sunflower_pkg;

    localparam int ADC_WIDTH      = 12;
    localparam int DEF_SAMPLE_DIV = 50000;  // 1 ms at 50 MHz
    localparam int DEF_AVG_LOG2   = 4;      // 16 samples per window

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : sunflower_pkg

// File: rtl/adc_sample_averager_if.sv
// -----------------------------------------------------------------------------
// adc_sample_averager_if
// Control, ADC data and result signals of the sample averager.
//   master : drives enable, peak_clr, adc_data; observes the results
//   slave  : the averager itself
//   enable     run/stop level
//   peak_clr   single-cycle clear of the peak register
//   adc_data   raw ADC bus, asynchronous to clk
//   avg_value  most recent window average
//   avg_valid  one-cycle pulse when avg_value updates
//   peak_value largest average since reset or last peak_clr
//   busy       high while a window is in progress
// -----------------------------------------------------------------------------
interface adc_sample_averager_if #(
    parameter int WIDTH = sunflower_pkg::ADC_WIDTH
);
    logic             enable;
    logic             peak_clr;
    logic [WIDTH-1:0] adc_data;
    logic [WIDTH-1:0] avg_value;
    logic             avg_valid;
    logic [WIDTH-1:0] peak_value;
    logic             busy;

    modport master (
        output enable, peak_clr, adc_data,
        input  avg_value, avg_valid, peak_value, busy
    );

    modport slave (
        input  enable, peak_clr, adc_data,
        output avg_value, avg_valid, peak_value, busy
    );
endinterface : adc_sample_averager_if

// File: rtl/adc_sample_averager_adc_sync.sv
// -----------------------------------------------------------------------------
// adc_sync
// Two-flop synchroniser bringing the asynchronous ADC word into clk.
//   clk  system clock
//   d_i  asynchronous input word
//   q_o  synchronised word, two cycles after d_i
// -----------------------------------------------------------------------------
module adc_sync #(
    parameter int WIDTH = sunflower_pkg::ADC_WIDTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: pure data flops carry no reset; their contents are flushed by the
    // live input within two cycles, and omitting reset keeps them simple flops.
    always_ff @(posedge clk) begin
        meta_q <= d_i;
        sync_q <= meta_q;
    end

    assign q_o = sync_q;
endmodule : adc_sync

// File: rtl/adc_sample_averager.sv
// -----------------------------------------------------------------------------
// adc_sample_averager
// Samples the synchronised ADC word every SAMPLE_DIV cycles, averages each
// window of 2^AVG_LOG2 samples and tracks the peak average.
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      slave side of adc_sample_averager_if (enable, peak_clr,
//            adc_data in; avg_value, avg_valid, peak_value, busy out)
// -----------------------------------------------------------------------------
module adc_sample_averager
    import sunflower_pkg::*;
#(
    parameter int WIDTH      = ADC_WIDTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int AVG_LOG2   = DEF_AVG_LOG2
) (
    input logic                  clk,
    input logic                  reset_n,
    adc_sample_averager_if.slave bus
);
    localparam int ACC_W  = WIDTH + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TICK_W = $clog2(SAMPLE_DIV);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [WIDTH-1:0]  sync_data;
    state_e            state_q;
    logic [TICK_W-1:0] tick_cnt_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic [ACC_W-1:0]  acc_q;
    logic [WIDTH-1:0]  avg_value_q;
    logic              avg_valid_q;
    logic [WIDTH-1:0]  peak_value_q;

    logic [ACC_W-1:0]  acc_d;
    logic [WIDTH-1:0]  avg_d;
    logic              tick_hit;

    adc_sync #(.WIDTH(WIDTH)) u_adc_sync (
        .clk (clk),
        .d_i (bus.adc_data),
        .q_o (sync_data)
    );

    // NOTE: every signal is assigned on every pass, so no latch is inferred.
    always_comb begin
        acc_d    = acc_q + ACC_W'(sync_data);
        avg_d    = WIDTH'(acc_d >> AVG_LOG2);
        tick_hit = (tick_cnt_q == TICK_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; later assignments in the block take priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            sample_cnt_q <= '0;
            acc_q        <= '0;
            avg_value_q  <= '0;
            avg_valid_q  <= 1'b0;
            peak_value_q <= '0;
        end else begin
            avg_valid_q <= 1'b0;

            // A clear while the DONE pulse is showing lands on the fresh
            // average, so clear and update combine without losing a window.
            if (bus.peak_clr) begin
                peak_value_q <= (state_q == DONE) ? avg_value_q : '0;
            end

            case (state_q)
                IDLE: begin
                    tick_cnt_q   <= '0;
                    sample_cnt_q <= '0;
                    acc_q        <= '0;
                    if (bus.enable) state_q <= WAIT;
                end

                WAIT: begin
                    if (!bus.enable) begin
                        // Abort: drop the partial window, keep the outputs.
                        state_q      <= IDLE;
                        tick_cnt_q   <= '0;
                        sample_cnt_q <= '0;
                        acc_q        <= '0;
                    end else if (tick_hit) begin
                        tick_cnt_q   <= '0;
                        acc_q        <= acc_d;
                        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
                        if (sample_cnt_q == SAMPLE_LAST) begin
                            // Results are registered on the edge into DONE so
                            // avg_valid is high during the DONE cycle itself.
                            state_q     <= DONE;
                            avg_value_q <= avg_d;
                            avg_valid_q <= 1'b1;
                            if (bus.peak_clr || (avg_d > peak_value_q)) begin
                                peak_value_q <= avg_d;
                            end
                        end
                    end else begin
                        tick_cnt_q <= tick_cnt_q + TICK_W'(1);
                    end
                end

                DONE: begin
                    tick_cnt_q   <= '0;
                    sample_cnt_q <= '0;
                    acc_q        <= '0;
                    state_q      <= bus.enable ? WAIT : IDLE;
                end

                default: begin
                    state_q      <= IDLE;
                    tick_cnt_q   <= '0;
                    sample_cnt_q <= '0;
                    acc_q        <= '0;
                end
            endcase
        end
    end

    assign bus.avg_value  = avg_value_q;
    assign bus.avg_valid  = avg_valid_q;
    assign bus.peak_value = peak_value_q;
    assign bus.busy       = (state_q == WAIT);
endmodule : adc_sample_averager

// File: tb/tb_adc_sample_averager.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_averager
// Directed bench for adc_sample_averager with SAMPLE_DIV=4, AVG_LOG2=2
// (17-cycle window period). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_adc_sample_averager;

    logic clk = 1'b0;
    logic reset_n;

    int n_cmp  = 0;
    int n_fail = 0;

    adc_sample_averager_if #(.WIDTH(12)) bus ();

    adc_sample_averager #(
        .WIDTH      (12),
        .SAMPLE_DIV (4),
        .AVG_LOG2   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag, input int avg, input int valid,
                             input int peak, input int busy);
        check({tag, "_avg"},   bus.avg_value,  avg);
        check({tag, "_valid"}, bus.avg_valid,  valid);
        check({tag, "_peak"},  bus.peak_value, peak);
        check({tag, "_busy"},  bus.busy,       busy);
    endtask

    // Called #1 after the edge that entered WAIT; returns #1 after the edge
    // that entered DONE. Sample i is taken on entry+4(i+1) and sees the ADC
    // value present two edges earlier, so each value is driven at entry+4i+1.
    task automatic window(input logic [11:0] s0, input logic [11:0] s1,
                          input logic [11:0] s2, input logic [11:0] s3,
                          input int exp_avg, input int exp_peak);
        logic [11:0] s [4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            check("win_valid_low", bus.avg_valid, 0);
            check("win_busy",      bus.busy,      1);
            step();
            bus.adc_data = s[i];
            for (int j = 0; j < 3; j++) begin
                check("win_valid_low", bus.avg_valid, 0);
                check("win_busy",      bus.busy,      1);
                step();
            end
        end
        check_all("win_done", exp_avg, 1, exp_peak, 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.enable   = 1'b0;
        bus.peak_clr = 1'b0;
        bus.adc_data = 12'd0;

        // Reset and idle
        repeat (3) step();
        check_all("reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_valid", bus.avg_valid, 0);
            check("idle_busy",  bus.busy,      0);
        end
        check_all("idle_end", 0, 0, 0, 0);

        // Constant input, back-to-back windows 17 cycles apart
        bus.adc_data = 12'd100;
        bus.enable   = 1'b1;
        step();
        window(100, 100, 100, 100, 100, 100);
        step();
        window(100, 100, 100, 100, 100, 100);

        // Truncation and full-scale
        step();
        window(1, 2, 2, 2, 1, 100);
        step();
        window(4095, 4095, 4095, 4095, 4095, 4095);

        // Window completes, then stop
        bus.enable = 1'b0;
        step();
        check_all("stop_idle", 4095, 0, 4095, 0);

        // Peak clear outside DONE
        bus.peak_clr = 1'b1;
        step();
        bus.peak_clr = 1'b0;
        check_all("clr_idle", 4095, 0, 0, 0);

        // Peak tracking 300, 200, 500
        bus.enable = 1'b1;
        step();
        window(300, 300, 300, 300, 300, 300);
        step();
        window(200, 200, 200, 200, 200, 300);
        step();
        window(500, 500, 500, 500, 500, 500);
        bus.enable = 1'b0;
        step();
        bus.peak_clr = 1'b1;
        step();
        bus.peak_clr = 1'b0;
        check_all("clr_between", 500, 0, 0, 0);

        // Peak clear during the DONE cycle of a window averaging 50
        bus.enable = 1'b1;
        step();
        window(700, 700, 700, 700, 700, 700);
        step();
        window(50, 50, 50, 50, 50, 700);
        bus.peak_clr = 1'b1;
        step();
        bus.peak_clr = 1'b0;
        check_all("clr_done", 50, 0, 50, 1);

        // Abort after two samples of 1000
        bus.adc_data = 12'd1000;
        repeat (8) step();
        check("abort_busy_before", bus.busy, 1);
        bus.enable = 1'b0;
        step();
        check_all("abort_idle", 50, 0, 50, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort_no_valid", bus.avg_valid, 0);
        end
        bus.enable = 1'b1;
        step();
        window(10, 10, 10, 10, 10, 50);

        // Mid-window reset
        step();
        repeat (6) step();
        check("pre_reset_busy", bus.busy, 1);
        reset_n = 1'b0;
        step();
        check_all("mid_reset", 0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        window(20, 20, 20, 20, 20, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_adc_sample_averager

// File: doc/adc_sample_averager.md
# adc_sample_averager

Front-end stage of the sunflower light-sensing path. It captures the 12-bit parallel ADC word from the GPIO header, resynchronises it into the clk domain, and takes one sample every SAMPLE_DIV cycles. It averages each window of 2^AVG_LOG2 samples and tracks the peak average seen since the last clear. avg_value/avg_valid feed the max comparator and max register; peak_value drives the binary-to-BCD converter and 7-segment display.

## Interface
Parameters:
- WIDTH, 12, ADC word width.
- SAMPLE_DIV, 50000, clk cycles between samples (1 ms at 50 MHz); legal range 2..2^20.
- AVG_LOG2, 4, log2 of samples per averaging window (16); legal range 0..8.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- enable  in  1  run/stop; level-sensitive.
- peak_clr  in  1  single-cycle clear of the peak register.
- adc_data  in  WIDTH  raw ADC bus, asynchronous to clk.
- avg_value  out  WIDTH  most recent window average.
- avg_valid  out  1  one-cycle pulse when avg_value updates.
- peak_value  out  WIDTH  largest avg_value since reset or the last peak_clr.
- busy  out  1  high while a window is in progress (WAIT state).

## Operation
- adc_data passes through a 2-flop synchroniser. The sampled value is the synchroniser output, sync_data.
- Accumulator acc is WIDTH+AVG_LOG2 bits wide and cannot overflow. sample_cnt is AVG_LOG2 bits wide (minimum 1). tick_cnt is clog2(SAMPLE_DIV) bits wide.
- IDLE:
  - tick_cnt, sample_cnt and acc are held at 0.
  - If enable=1, go to WAIT.
- WAIT:
  - tick_cnt increments every cycle.
  - When tick_cnt==SAMPLE_DIV-1: tick_cnt←0, acc←acc+sync_data, sample_cnt←sample_cnt+1.
  - If that tick is the last sample (sample_cnt==2^AVG_LOG2-1), go to DONE.
  - If enable=0 in any WAIT cycle, abort: go to IDLE, discard acc and counters. Outputs hold their values.
- DONE (exactly one cycle):
  - avg_value←acc>>AVG_LOG2 (truncating) and avg_valid=1.
  - If new average > peak_value, peak_value←new average.
  - acc, sample_cnt and tick_cnt ← 0.
  - Next state is WAIT if enable=1, otherwise IDLE. The window in progress always completes.
- peak_clr:
  - In a non-DONE cycle: peak_value←0.
  - In the same cycle as DONE: peak_value←new average. Clear and update combine; no sample is lost.
- AVG_LOG2=0: every sample is reported directly and avg_value equals that sample.

## Timing
- Reset (reset_n=0 at a clk edge) gives: state IDLE, all counters and acc 0, avg_value=0, avg_valid=0, peak_value=0, busy=0. Reset in mid-window discards the partial window.
- Latency from adc_data change to sync_data: 2 cycles.
- Latency from enable rising to first WAIT cycle: 1 cycle.
- First sample: WAIT cycle SAMPLE_DIV.
- Window period in continuous operation: 2^AVG_LOG2·SAMPLE_DIV + 1 cycles.
- avg_valid is registered and asserts in the DONE cycle. avg_value and peak_value change on the same edge and stay stable until the next DONE.
- busy=1 exactly while in WAIT.
- peak_clr acts on the edge it is sampled; peak_value reads 0 the next cycle (except in the DONE case above).

## Structure
- Shared package sunflower_pkg holds:
  - ADC_WIDTH=12.
  - The state encoding (IDLE=2'b00, WAIT=2'b01, DONE=2'b10).
  - The default SAMPLE_DIV and AVG_LOG2.
- One sub-module, adc_sync: a parameterised-width 2-flop synchroniser with no reset on the data flops.
- Tick counter, accumulator, FSM and peak register live in the top block.

## Test plan
Sim parameters: SAMPLE_DIV=4, AVG_LOG2=2.
- Reset / idle: reset_n=0 for 3 cycles, then hold enable=0 for 20 cycles → all outputs 0 throughout, busy=0.
- Constant input: adc_data=12'd100, enable=1 → first avg_valid 17 cycles after the WAIT entry, avg_value=100, peak_value=100; then avg_valid repeats every 17 cycles.
- Truncation: window samples 1,2,2,2 (sum 7) → avg_value=1. Samples 4095×4 → avg_value=4095 with no overflow.
- Peak tracking: successive window averages 300, 200, 500 → peak_value 300, 300, 500. A peak_clr pulse between windows → 0. A peak_clr in a DONE cycle with average 50 → peak_value=50.
- Abort: drop enable after 2 samples of 1000 → return to IDLE, no avg_valid. Re-enable with input 10 → next avg_value=10, not contaminated by the aborted samples.
- Mid-run reset: reset_n=0 for one cycle during WAIT → all outputs 0. With enable=1 the restart is clean, and the first avg_valid comes after the full 17-cycle period.
